conv_ctrl: RTL

- Sequencer for the binary 5x5 convolution engine.
- Accepts one layer command and runs the engine once per kernel, for NK kernels in turn.
- For each kernel it:
  - streams that kernel's 25 sign bits from a 1-bit weight memory;
  - holds the engine's start;
  - launches the sliding-window feeder;
  - counts output-valid strobes and checks the count when the engine signals done.
- Sits between the layer-level top controller and the conv engine plus window feeder.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_wt_streamer.sv | 38 +++
 rtl/conv_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the binary 5x5 conv sequencer.
package conv_pkg;

  localparam int K     = 5;
  localparam int KK    = K * K;
  localparam int NI0   = 28;
  localparam int NI1   = 12;
  localparam int EXP0  = (NI0 - K + 1) * (NI0 - K + 1);
  localparam int EXP1  = (NI1 - K + 1) * (NI1 - K + 1);
  localparam int OVC_W = 11;
  localparam int LC_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP
  } state_t;

  function automatic logic [OVC_W-1:0] exp_count(
    input logic layer
  );
    return layer ? OVC_W'(EXP1) : OVC_W'(EXP0);
  endfunction

endpackage

// File: rtl/conv_wt_streamer.sv
// LOAD-phase counter, weight address generator and 1-cycle read alignment.
module conv_wt_streamer
  import conv_pkg::*;
#(
  parameter int WADDR_W = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load,
  input  logic [WADDR_W-1:0] kbase,
  input  logic               wt_rdata,
  output logic [LC_W-1:0]    lcnt,
  output logic               last,
  output logic [WADDR_W-1:0] wt_addr,
  output logic               weight_en,
  output logic               weight
);

  logic [LC_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load && !last) begin
      cnt <= cnt + LC_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign lcnt      = cnt;
  assign last      = load && (cnt == LC_W'(KK));
  assign weight_en = load && (cnt < LC_W'(KK));
  assign wt_addr   = weight_en ? kbase + WADDR_W'(cnt) : '0;
  // read data trails the address by one cycle
  assign weight    = (load && cnt != '0) ? wt_rdata : 1'b0;

endmodule

// File: rtl/conv_ctrl.sv
// Per-layer sequencer: loads each kernel's weights, runs the engine,
// checks output-valid counts and steps through all kernels.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int WADDR_W = 12,
  parameter int NK_W    = 6,
  parameter int WIN_LAG = 2,
  parameter int TIMEOUT = 2047
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_layer,
  input  logic [NK_W-1:0]    cmd_nk,
  input  logic [WADDR_W-1:0] cmd_wbase,
  output logic [WADDR_W-1:0] wt_addr,
  input  logic               wt_rdata,
  output logic               conv_start,
  output logic               conv_weight_en,
  output logic               conv_weight,
  output logic               conv_state,
  output logic               win_start,
  input  logic               conv_ovalid,
  input  logic               conv_done,
  output logic [NK_W-1:0]    ker_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic                 layer_q;
  logic [NK_W-1:0]      nk_last_q;
  logic [WADDR_W-1:0]   kbase_q;
  logic [NK_W-1:0]      ker_q;
  logic [OVC_W-1:0]     ovcnt_q;
  logic [OVC_W-1:0]     ov_next;
  logic [RUN_W-1:0]     run_q;
  logic                 err_q;
  logic                 done_q;
  logic                 done_d;
  logic                 accept;
  logic                 is_load;
  logic                 is_run;
  logic                 is_gap;
  logic                 last_ker;
  logic                 tmo;
  logic [LC_W-1:0]      lcnt;
  logic                 lload_last;

  assign is_load  = (state_q == S_LOAD);
  assign is_run   = (state_q == S_RUN);
  assign is_gap   = (state_q == S_GAP);
  assign cmd_ready = rstn && (state_q == S_IDLE);
  assign accept   = cmd_valid && cmd_ready;
  assign last_ker = (ker_q == nk_last_q);
  assign tmo      = (run_q == RUN_W'(TIMEOUT - 1));
  assign ov_next  = ovcnt_q
                  + OVC_W'(conv_ovalid && (ovcnt_q != '1));

  conv_wt_streamer #(
    .WADDR_W (WADDR_W)
  ) u_stream (
    .clk       (clk),
    .rstn      (rstn),
    .load      (is_load),
    .kbase     (kbase_q),
    .wt_rdata  (wt_rdata),
    .lcnt      (lcnt),
    .last      (lload_last),
    .wt_addr   (wt_addr),
    .weight_en (conv_weight_en),
    .weight    (conv_weight)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_LOAD;
      S_LOAD: if (lload_last) state_d = S_RUN;
      S_RUN:  if (conv_done || tmo) state_d = S_GAP;
      S_GAP: begin
        if (last_ker) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      layer_q   <= 1'b0;
      nk_last_q <= '0;
      kbase_q   <= '0;
      ker_q     <= '0;
      ovcnt_q   <= '0;
      run_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        layer_q   <= cmd_layer;
        nk_last_q <= (cmd_nk == '0) ? '0 : cmd_nk - NK_W'(1);
        kbase_q   <= cmd_wbase;
        ker_q     <= '0;
        err_q     <= 1'b0;
      end
      if (is_run) begin
        ovcnt_q <= ov_next;
        run_q   <= run_q + RUN_W'(1);
        // count includes an ovalid coincident with done
        if (conv_done && (ov_next != exp_count(layer_q)))
          err_q <= 1'b1;
        if (!conv_done && tmo)
          err_q <= 1'b1;
      end else begin
        run_q <= '0;
      end
      if (is_gap) begin
        ovcnt_q <= '0;
        if (!last_ker) begin
          ker_q   <= ker_q + NK_W'(1);
          kbase_q <= kbase_q + WADDR_W'(KK);
        end
      end
    end
  end

  assign conv_start = is_load || is_run;
  assign win_start  = is_load && (lcnt == LC_W'(WIN_LAG));
  assign conv_state = layer_q;
  assign ker_idx    = ker_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule
